// File: rtl/countdown_timer.sv
// Loadable down-counter with terminal-count pulse and optional auto-reload.
// Sequencing timers use it for one-shot delays and periodic ticks.
module countdown_timer #(
  parameter int Size = 5
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            load,
  input  logic [Size-1:0] load_value,
  input  logic            start,
  input  logic            stop,
  input  logic            pause,
  input  logic            auto_reload,
  output logic [Size-1:0] count,
  output logic            busy,
  output logic            expired
);

  // state | meaning
  // IDLE  | loaded or stopped, count holds, waiting for start
  // RUN   | decrementing once per unpaused edge
  // DONE  | terminal count reached, start reloads from reload_reg
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [Size-1:0] ZERO = '0;
  localparam logic [Size-1:0] ONE  = {{(Size-1){1'b0}}, 1'b1};

  state_t          state;
  logic [Size-1:0] reload_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      count      <= ZERO;
      reload_reg <= ZERO;
      busy       <= 1'b0;
      expired    <= 1'b0;
    end else begin
      expired <= 1'b0;
      if (load) begin
        count      <= load_value;
        reload_reg <= load_value;
        state      <= IDLE;
        busy       <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              if (count == ZERO) begin
                state   <= DONE;
                expired <= 1'b1;
              end else begin
                state <= RUN;
                busy  <= 1'b1;
              end
            end
          end
          DONE: begin
            if (start) begin
              count <= reload_reg;
              if (reload_reg == ZERO) begin
                expired <= 1'b1;
              end else begin
                state <= RUN;
                busy  <= 1'b1;
              end
            end
          end
          RUN: begin
            if (stop) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else if (!pause) begin
              if (count > ONE) begin
                count <= count - ONE;
              end else begin
                // terminal edge; a zero count here is treated as terminal too
                expired <= 1'b1;
                if (auto_reload && reload_reg != ZERO) begin
                  count <= reload_reg;
                end else begin
                  count <= ZERO;
                  state <= DONE;
                  busy  <= 1'b0;
                end
              end
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: directed scenarios then random stimulus,
// with a behavioural model supplying the expected outputs for every edge.
module tb_countdown_timer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       load = 1'b0, start = 1'b0, stop = 1'b0, pause = 1'b0, auto_reload = 1'b0;
  logic [4:0] load_value = '0;
  logic [4:0] count;
  logic       busy, expired;

  countdown_timer #(.Size(5)) dut (
    .clock(clock), .reset(reset), .load(load), .load_value(load_value),
    .start(start), .stop(stop), .pause(pause), .auto_reload(auto_reload),
    .count(count), .busy(busy), .expired(expired)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [4:0] c;
    logic       b;
    logic       e;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_err = 0;

  // behavioural model
  typedef enum {M_IDLE, M_RUN, M_DONE} mode_t;
  mode_t m_mode = M_IDLE;
  int    m_count = 0;
  int    m_reload = 0;

  task automatic model_reset();
    m_mode = M_IDLE; m_count = 0; m_reload = 0;
  endtask

  function automatic exp_t model_edge(input bit ld, input int lv, input bit st,
                                      input bit sp, input bit ps, input bit ar);
    exp_t r;
    bit   ex = 0;
    int   base;
    if (ld) begin
      m_count = lv; m_reload = lv; m_mode = M_IDLE;
    end else if (m_mode == M_RUN && sp) begin
      m_mode = M_IDLE;
    end else if (m_mode != M_RUN && st) begin
      base = (m_mode == M_DONE) ? m_reload : m_count;
      m_count = base;
      if (base == 0) begin
        m_mode = M_DONE; ex = 1;
      end else m_mode = M_RUN;
    end else if (m_mode == M_RUN && !ps) begin
      m_count = m_count - 1;
      if (m_count == 0) begin
        ex = 1;
        if (ar) m_count = m_reload;
        else m_mode = M_DONE;
      end
    end
    r.c = m_count[4:0];
    r.b = (m_mode == M_RUN);
    r.e = ex;
    return r;
  endfunction

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // monitor: one scoreboard entry per edge that had stimulus issued
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("count", count, e.c);
        check("busy", busy, e.b);
        check("expired", expired, e.e);
      end
    end
  end

  task automatic drive(input bit ld, input int lv, input bit st,
                       input bit sp, input bit ps, input bit ar);
    @(negedge clock);
    load = ld; load_value = lv[4:0]; start = st; stop = sp; pause = ps; auto_reload = ar;
    exp_q.push_back(model_edge(ld, lv, st, sp, ps, ar));
  endtask

  task automatic idle(input int n, input bit ar = 0);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, ar);
  endtask

  task automatic async_reset();
    @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    check("rst_count", count, 0);
    check("rst_busy", busy, 0);
    check("rst_expired", expired, 0);
    model_reset();
    load = 0; start = 0; stop = 0; pause = 0; auto_reload = 0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    int guard;
    #12;
    check("init_count", count, 0);
    check("init_busy", busy, 0);
    check("init_expired", expired, 0);
    @(negedge clock);
    reset = 1'b0;

    // basic countdown
    drive(1, 3, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0);
    idle(5);
    // maximum value, then make sure it does not wrap
    drive(1, 31, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0);
    idle(34);
    // auto-reload, then drop it
    drive(1, 2, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 1);
    idle(7, 1);
    idle(4, 0);
    // reload register of 1 with auto-reload
    drive(1, 1, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 1);
    idle(4, 1);
    idle(2, 0);
    // pause and stop
    drive(1, 5, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0);
    idle(2);
    drive(0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 1, 0);
    drive(0, 0, 1, 0, 1, 0);
    drive(0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 1, 0, 0);
    drive(0, 0, 1, 0, 0, 0);
    idle(4);
    // restart from DONE reloads
    drive(0, 0, 1, 0, 0, 0);
    idle(6);
    // priority and zero
    drive(1, 4, 1, 0, 0, 0);
    idle(2);
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0);
    idle(2);
    // asynchronous reset mid-run
    drive(1, 10, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0);
    guard = 0;
    while (m_count != 6 && guard < 20) begin
      idle(1);
      guard++;
    end
    check("reach_count6", m_count, 6);
    async_reset();
    drive(0, 0, 1, 0, 0, 0);
    idle(2);

    // randomized stimulus
    for (int i = 0; i < 1500; i++) begin
      bit ld, st, sp, ps, ar;
      int lv;
      if ($urandom_range(0, 199) == 0) async_reset();
      ld = ($urandom_range(0, 99) < 6);
      lv = ($urandom_range(0, 9) == 0) ? 31 : $urandom_range(0, 7);
      st = ($urandom_range(0, 99) < 15);
      sp = ($urandom_range(0, 99) < 4);
      ps = ($urandom_range(0, 99) < 20);
      ar = $urandom_range(0, 1);
      drive(ld, lv, st, sp, ps, ar);
    end

    @(posedge clock);
    #2;
    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
